// File: rtl/add_sub_acc_mc_if.sv
// Purpose: op-request / result-beat bundle for add_sub_acc_mc.
//   master : op source and result consumer (drives in_*, out_ready)
//   slave  : the accumulator (drives in_ready, out_*)
// Request : in_valid, in_ready, in_ch[CW], in_op[2], in_data[N]
// Result  : out_valid, out_ready, out_ch[CW], out_sum[N], out_carry, out_ovf, out_sat, out_err
interface add_sub_acc_mc_if #(
  parameter int unsigned N  = 8,
  parameter int unsigned CH = 4
);
  localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1;

  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ch;
  logic [1:0]    in_op;
  logic [N-1:0]  in_data;

  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ch;
  logic [N-1:0]  out_sum;
  logic          out_carry;
  logic          out_ovf;
  logic          out_sat;
  logic          out_err;

  modport master (
    output in_valid, in_ch, in_op, in_data, out_ready,
    input  in_ready, out_valid, out_ch, out_sum, out_carry, out_ovf, out_sat, out_err
  );

  modport slave (
    input  in_valid, in_ch, in_op, in_data, out_ready,
    output in_ready, out_valid, out_ch, out_sum, out_carry, out_ovf, out_sat, out_err
  );
endinterface

// File: rtl/add_sub_acc_mc.sv
// Purpose: CH-channel N-bit add/subtract accumulator with a 1-deep registered result
//   stage, carry/borrow and signed-overflow flags, and per-channel sticky overflow.
// Ports:
//   clk        : clock, posedge
//   aclr       : synchronous active-low reset
//   bus        : add_sub_acc_mc_if.slave (op request in, result beat out)
//   ovf_sticky : per-channel sticky overflow, cleared by load/clear on that channel
// Build option: define ADD_SUB_SAT_EN to clamp overflowing results to the signed
//   limits (out_sat reports the clamp); otherwise results wrap and out_sat is 0.
module add_sub_acc_mc #(
  parameter int unsigned N  = 8,
  parameter int unsigned CH = 4
) (
  input  logic                  clk,
  input  logic                  aclr,
  add_sub_acc_mc_if.slave       bus,
  output logic [CH-1:0]         ovf_sticky
);
  localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_LOAD = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  logic [CH-1:0][N-1:0] acc_q;
  logic [CH-1:0]        sticky_q;

  logic          out_valid_q;
  logic [CW-1:0] out_ch_q;
  logic [N-1:0]  out_sum_q;
  logic          out_carry_q;
  logic          out_ovf_q;
  logic          out_sat_q;
  logic          out_err_q;

  op_e           op;
  logic          accept;
  logic [CH-1:0] sel;
  logic          ch_ok;
  logic [N-1:0]  s;
  logic [N:0]    sum_ext;
  logic [N:0]    diff_ext;
  logic [N-1:0]  r;
  logic          c;
  logic          ovf;
  logic          sat;

  assign op       = op_e'(bus.in_op);
  assign bus.in_ready = ~out_valid_q | bus.out_ready;
  assign accept   = bus.in_valid & bus.in_ready;

  // Channel decode and current accumulator read; an out-of-range channel selects nothing.
  always_comb begin
    sel   = '0;
    ch_ok = 1'b0;
    s     = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (bus.in_ch == CW'(i)) begin
        sel[i] = 1'b1;
        ch_ok  = 1'b1;
        s      = acc_q[i];
      end
    end
  end

  assign sum_ext  = {1'b0, s} + {1'b0, bus.in_data};
  assign diff_ext = {1'b0, s} - {1'b0, bus.in_data};

  // Result and flags for the presented op.
  always_comb begin
    r   = '0;
    c   = 1'b0;
    ovf = 1'b0;
    sat = 1'b0;
    case (op)
      OP_ADD: begin
        r   = sum_ext[N-1:0];
        c   = sum_ext[N];
        ovf = (s[N-1] == bus.in_data[N-1]) && (sum_ext[N-1] != s[N-1]);
      end
      OP_SUB: begin
        r   = diff_ext[N-1:0];
        c   = diff_ext[N];
        ovf = (s[N-1] != bus.in_data[N-1]) && (diff_ext[N-1] != s[N-1]);
      end
      OP_LOAD: r = bus.in_data;
      OP_CLR:  r = '0;
      default: r = '0;
    endcase
`ifdef ADD_SUB_SAT_EN
    // Overflow direction follows the accumulator sign: a positive S can only overflow upward.
    if (ovf) begin
      sat = 1'b1;
      r   = s[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
`endif
    if (!ch_ok) begin
      r   = '0;
      c   = 1'b0;
      ovf = 1'b0;
      sat = 1'b0;
    end
  end

  // Accumulators, sticky bits and the result register.
  always_ff @(posedge clk) begin
    if (!aclr) begin
      acc_q       <= '0;
      sticky_q    <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_sum_q   <= '0;
      out_carry_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_sat_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_ch_q    <= bus.in_ch;
      out_sum_q   <= r;
      out_carry_q <= c;
      out_ovf_q   <= ovf;
      out_sat_q   <= sat;
      out_err_q   <= ~ch_ok;
      for (int unsigned i = 0; i < CH; i++) begin
        if (sel[i]) begin
          acc_q[i]    <= r;
          sticky_q[i] <= (op == OP_LOAD || op == OP_CLR) ? 1'b0 : (sticky_q[i] | ovf);
        end
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_carry = out_carry_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_err   = out_err_q;
  assign ovf_sticky    = sticky_q;
endmodule

// File: tb/tb_add_sub_acc_mc.sv
// Purpose: randomized + directed scoreboard bench for add_sub_acc_mc (N=8, CH=4).
// Driver issues ops after posedge; a reference model decides acceptance and pushes
// expected beats; a monitor at negedge compares presented beats and flags.
module tb_add_sub_acc_mc;
  localparam int unsigned N  = 8;
  localparam int unsigned CH = 4;
  localparam int unsigned CW = 2;
  localparam int MOD  = 1 << N;
  localparam int HALF = 1 << (N - 1);

  logic          clk = 1'b0;
  logic          aclr;
  logic [CH-1:0] ovf_sticky;

  always #5 clk = ~clk;

  add_sub_acc_mc_if #(.N(N), .CH(CH)) bus ();

  add_sub_acc_mc #(.N(N), .CH(CH)) dut (
    .clk        (clk),
    .aclr       (aclr),
    .bus        (bus),
    .ovf_sticky (ovf_sticky)
  );

  typedef struct {
    int ch;
    int sum;
    bit c;
    bit ovf;
    bit sat;
    bit err;
  } beat_t;

  int n_vec = 0;
  int n_err = 0;

  int            m_acc [CH];
  logic [CH-1:0] m_sticky = '0;
  bit            m_ov     = 1'b0;
  bit            m_fire   = 1'b0;
  bit            chk_rst  = 1'b0;
  bit            rand_done = 1'b0;
  beat_t         q[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int to_signed(input int v);
    return (v >= HALF) ? v - MOD : v;
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic beat_t model_op(input int ch, input int op, input int a);
    beat_t b;
    int s, sr, res;
    b = '{default: 0};
    b.ch = ch;
    if (ch >= int'(CH)) begin
      b.err = 1'b1;
      return b;
    end
    s  = m_acc[ch];
    sr = 0;
    case (op)
      0: begin res = s + a; b.c = (res >= MOD); sr = to_signed(s) + to_signed(a); end
      1: begin res = s - a; b.c = (a > s);      sr = to_signed(s) - to_signed(a); end
      2: res = a;
      default: res = 0;
    endcase
    b.ovf = (op < 2) && (sr > HALF - 1 || sr < -HALF);
    b.sum = ((res % MOD) + MOD) % MOD;
`ifdef ADD_SUB_SAT_EN
    if (b.ovf) begin
      b.sat = 1'b1;
      b.sum = (sr > 0) ? HALF - 1 : HALF;
    end
`endif
    m_acc[ch] = b.sum;
    if (op >= 2) m_sticky[ch] = 1'b0;
    else if (b.ovf) m_sticky[ch] = 1'b1;
    return b;
  endfunction

  // Model: decides what the coming edge does, from stimulus only.
  initial begin
    foreach (m_acc[i]) m_acc[i] = 0;
    forever begin
      @(negedge clk);
      #1;
      if (aclr !== 1'b1) begin
        q.delete();
        foreach (m_acc[i]) m_acc[i] = 0;
        m_sticky = '0;
        m_ov     = 1'b0;
        m_fire   = 1'b0;
        chk_rst  = 1'b1;
      end else begin
        m_fire = bus.in_valid && (!m_ov || bus.out_ready);
        m_ov   = m_fire || (m_ov && !bus.out_ready);
        if (m_fire) q.push_back(model_op(int'(bus.in_ch), int'(bus.in_op), int'(bus.in_data)));
      end
    end
  end

  // Monitor: compares what the DUT presents against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      check("in_ready", 32'(bus.in_ready), 32'((q.size() == 0) || bus.out_ready));
      check("sticky", 32'(ovf_sticky), 32'(m_sticky));
      if (chk_rst) begin
        chk_rst = 1'b0;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_flds", {bus.out_ch, bus.out_sum, bus.out_carry, bus.out_ovf,
                               bus.out_sat, bus.out_err}, 0);
      end
      if (bus.out_valid === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_beat", 32'(bus.out_valid), 0);
        end else begin
          check("out_ch",    32'(bus.out_ch),    32'(q[0].ch));
          check("out_sum",   32'(bus.out_sum),   32'(q[0].sum));
          check("out_carry", 32'(bus.out_carry), 32'(q[0].c));
          check("out_ovf",   32'(bus.out_ovf),   32'(q[0].ovf));
          check("out_sat",   32'(bus.out_sat),   32'(q[0].sat));
          check("out_err",   32'(bus.out_err),   32'(q[0].err));
          if (bus.out_ready) void'(q.pop_front());
        end
      end else if (q.size() != 0) begin
        check("out_valid", 32'(bus.out_valid), 1);
        void'(q.pop_front());
      end
    end
  end

  // Present one op from posedge+1 and hold it until the model sees it accepted.
  task automatic issue(input int ch, input int op, input int data, output int waited);
    bus.in_valid = 1'b1;
    bus.in_ch    = CW'(ch);
    bus.in_op    = 2'(op);
    bus.in_data  = N'(data);
    waited = 0;
    do begin
      @(posedge clk);
      waited++;
    end while (!m_fire && waited < 100);
    if (!m_fire) check("accept_timeout", 0, 1);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    aclr          = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_ch     = '0;
    bus.in_op     = 2'b00;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Reset held two cycles with a request pending, then add 0 on every channel.
    repeat (2) @(posedge clk);
    #1;
    aclr = 1'b1;
    bus.in_valid = 1'b0;
    for (int ch = 0; ch < int'(CH); ch++) issue(ch, 0, 0, w);

    // Positive overflow on ch0.
    issue(0, 2, 'h7F, w);
    issue(0, 0, 'h01, w);

    // Borrow without overflow, then borrow with overflow on ch1.
    issue(1, 2, 'h05, w);
    issue(1, 1, 'h06, w);
    issue(1, 3, 0, w);
    issue(1, 1, 'h80, w);

    // Back-pressure: a queued op waits until the pending beat is consumed.
    idle();
    bus.out_ready = 1'b0;
    issue(2, 0, 7, w);
    fork
      issue(2, 0, 1, w);
      begin
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    check("stall_cycles", 32'(w), 6);

    // Back-to-back ops on alternating channels at full rate.
    issue(2, 3, 0, w);
    issue(3, 3, 0, w);
    issue(2, 0, 3, w);
    check("b2b_0", 32'(w), 1);
    issue(3, 0, 4, w);
    check("b2b_1", 32'(w), 1);
    issue(2, 0, 3, w);
    check("b2b_2", 32'(w), 1);

    // Clear drops the sticky bit; reset drops a stalled beat and all accumulators.
    issue(0, 3, 0, w);
    idle();
    bus.out_ready = 1'b0;
    issue(1, 0, 5, w);
    aclr = 1'b0;
    idle();
    aclr = 1'b1;
    bus.out_ready = 1'b1;
    for (int ch = 0; ch < int'(CH); ch++) issue(ch, 0, 0, w);

    // Random ops with random consumer back-pressure.
    fork
      begin
        for (int k = 0; k < 400; k++) begin
          int r, op;
          r  = int'($urandom_range(0, 9));
          op = (r < 4) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
          issue(int'($urandom_range(0, CH - 1)), op, int'($urandom_range(0, MOD - 1)), w);
          if ($urandom_range(0, 3) == 0) idle();
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join

    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    check("drain", 32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
